lsu_nbload_tag_ctl: RTL and testbench
=====================================

# lsu_nbload_tag_ctl

Allocates and tracks tags for non-blocking (bus-miss) loads in the LSU. Holds one entry per outstanding tag, suppresses stale writebacks on write-after-write and on flush, provides the decode-stage dependency check, and retires bus returns into a registered writeback. It sequences the `load_cam_pkt_t` resource between the LSU issue path and the bus return path.

## Interface
- `NUM_TAGS`, default 4: number of tags; must equal 2^`TAG_W`.
- `TAG_W`, default 2: tag width; equals `RV_LSU_NUM_NBLOAD_WIDTH`.
- Reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous active-high reset.
- `alloc_req`  in  1  a non-blocking load requests a tag.
- `alloc_rd`  in  5  destination register of the requesting load.
- `alloc_gnt`  out  1  tag granted in the same cycle (combinational).
- `alloc_tag`  out  `TAG_W`  granted tag; valid when `alloc_gnt`=1.
- `full`  out  1  no free tag (combinational).
- `flush`  in  1  pipeline flush; kills all outstanding writebacks.
- `ret_valid`  in  1  bus data return.
- `ret_tag`  in  `TAG_W`  tag of the return.
- `ret_spurious`  out  1  registered pulse: return hit a non-valid tag.
- `wb_valid`  out  1  registered register-file writeback strobe.
- `wb_rd`  out  5  writeback destination.
- `wb_tag`  out  `TAG_W`  tag being written back.
- `rs1_addr`, `rs2_addr`  in  5 each  decode source registers.
- `rs1_stall`, `rs2_stall`  out  1 each  source matches a pending writeback (combinational).
- `perf_full_cnt`  out  32  cycles with `alloc_req`&&`full` (see Configuration).
- `perf_alloc_cnt`  out  32  granted allocations (see Configuration).

## Operation
- Each entry is a `load_cam_pkt_t` {valid, wb, tag, rd}. Entry states: IDLE (valid=0), PEND (valid=1, wb=1), KILLED (valid=1, wb=0).
- Alloc: `alloc_gnt` = `alloc_req` && !`full` && !`flush`. `alloc_tag` is the lowest-indexed IDLE entry, taken from the start-of-cycle state. That entry becomes PEND with rd=`alloc_rd` on the next edge.
- WAW: on a grant, every PEND entry with rd == `alloc_rd` moves to KILLED on the same edge.
- Flush: every PEND entry moves to KILLED. `flush` blocks any grant in that cycle.
- Return to PEND: entry goes to IDLE; next cycle `wb_valid`=1 with that entry's rd and tag.
- Return to KILLED: entry goes to IDLE; no writeback.
- Return to IDLE: state unchanged; `ret_spurious`=1 next cycle.
- rd==0: the entry is allocated normally, but `wb_valid` is never raised for it and it never causes a stall.
- Stall: `rsN_stall` = any PEND entry has rd == `rsN_addr`, with `rsN_addr` != 0. KILLED entries never stall.
- Return and flush in the same cycle: the return is evaluated against the pre-flush state. A PEND entry returning in that cycle still writes back.

## Timing
- Reset: all entries IDLE. `wb_valid`, `wb_rd`, `wb_tag`, `ret_spurious` = 0. Perf counters = 0. `full`=0. `alloc_gnt`=0.
- Grant latency is 0 cycles. The entry is visible to stall logic and to `full` from the cycle after the grant.
- Writeback latency is 1 cycle after `ret_valid`. At most one return and one writeback per cycle.
- A tag freed by a return cannot be granted in the same cycle; it becomes grantable in the next cycle.
- A return may target an entry allocated in the previous cycle or any later cycle.
- Reset mid-operation discards all entries. Returns arriving after reset are reported as spurious.
- Perf counters saturate at 32'hFFFF_FFFF.

## Configuration
- `RV_NBLOAD_PERF_EN` defined: both perf counters are implemented and update as described above.
- `RV_NBLOAD_PERF_EN` undefined: the counters are not built and both `perf_*` outputs are tied to 0. The port list is identical in both cases.

## Structure
- `load_cam_pkt_t` comes from the shared types package.
- Add to the same package: an entry-state enum (IDLE/PEND/KILLED) used for assertions, and the localparam `NBLOAD_TAGS`.
- One sub-module: `nbload_ffs`, a parameterized find-first-set priority encoder. It returns the lowest free index and an any-free flag.

## Test plan
- Fill: four back-to-back requests with rd 1,2,3,4 → tags 0,1,2,3. Fifth request → `full`=1, `alloc_gnt`=0, `perf_full_cnt` increments by 1.
- Return and writeback: return tag 2 → next cycle `wb_valid`=1, `wb_rd`=3, `wb_tag`=2. Same-cycle request is denied. Next request gets tag 2.
- WAW: allocate rd=5 (tag 0), then allocate rd=5 (tag 1). During the pending interval, `rs1_addr`=5 → stall. Return tag 0 → no writeback. Return tag 1 → writeback rd 5.
- Flush: tags 0 and 1 PEND, `flush` pulsed together with `alloc_req` → no grant. Stalls drop the next cycle. Both later returns produce no writeback.
- Flush with same-cycle return to tag 0 (PEND) → tag 0 writes back; tag 1 killed.
- Spurious and reset: return tag 3 while IDLE → `ret_spurious` pulse. Assert `rst` with entries pending → all outputs 0, first allocation after reset gets tag 0.

Source files
------------

// File: rtl/lsu_nbload_tag_ctl_pkg.sv
// Shared types for the non-blocking load tag controller: the CAM entry packet,
// the entry-state view used by assertions, and the tag count.
package lsu_nbload_tag_ctl_pkg;

    localparam int NBLOAD_TAGS  = 4;
    localparam int NBLOAD_TAG_W = 2;

    typedef struct packed {
        logic                    valid;
        logic                    wb;
        logic [NBLOAD_TAG_W-1:0] tag;
        logic [4:0]              rd;
    } load_cam_pkt_t;

    typedef enum logic [1:0] {
        ENT_IDLE   = 2'd0,
        ENT_PEND   = 2'd1,
        ENT_KILLED = 2'd2
    } nbload_ent_e;

    function automatic nbload_ent_e ent_state(input load_cam_pkt_t e);
        if (!e.valid) return ENT_IDLE;
        return e.wb ? ENT_PEND : ENT_KILLED;
    endfunction

endpackage

// File: rtl/lsu_nbload_tag_ctl_ffs.sv
// nbload_ffs: find-first-set priority encoder returning the lowest set index
// of i_vec and a flag telling whether any bit is set.
module nbload_ffs #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] i_vec,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    always_comb begin
        o_idx = '0;
        o_any = |i_vec;
        // Scanning downward lets the lowest set bit win the last assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) o_idx = W'(i);
        end
    end

endmodule

// File: rtl/lsu_nbload_tag_ctl.sv
// Non-blocking load tag allocator / tracker with WAW and flush kill, decode
// stall check and registered writeback. Perf counters built when RV_NBLOAD_PERF_EN is defined.
module lsu_nbload_tag_ctl
    import lsu_nbload_tag_ctl_pkg::*;
#(
    parameter int NUM_TAGS = NBLOAD_TAGS,
    parameter int TAG_W    = NBLOAD_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_req,
    input  logic [4:0]       alloc_rd,
    output logic             alloc_gnt,
    output logic [TAG_W-1:0] alloc_tag,
    output logic             full,
    input  logic             flush,
    input  logic             ret_valid,
    input  logic [TAG_W-1:0] ret_tag,
    output logic             ret_spurious,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic [TAG_W-1:0] wb_tag,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    output logic             rs1_stall,
    output logic             rs2_stall,
    output logic [31:0]      perf_full_cnt,
    output logic [31:0]      perf_alloc_cnt
);

    load_cam_pkt_t    r_ent [NUM_TAGS];
    logic             r_wb_valid;
    logic [4:0]       r_wb_rd;
    logic [TAG_W-1:0] r_wb_tag;
    logic             r_ret_spurious;

    logic [NUM_TAGS-1:0] w_free;
    logic [TAG_W-1:0]    w_free_idx;
    logic                w_any_free;
    logic                w_ret_hit;
    logic                w_ret_wb;

    always_comb begin
        for (int i = 0; i < NUM_TAGS; i++) w_free[i] = !r_ent[i].valid;
    end

    nbload_ffs #(.N(NUM_TAGS), .W(TAG_W)) u_ffs (
        .i_vec (w_free),
        .o_idx (w_free_idx),
        .o_any (w_any_free)
    );

    assign full      = !w_any_free;
    assign alloc_gnt = alloc_req && w_any_free && !flush;
    assign alloc_tag = w_free_idx;

    // Return is judged on the start-of-cycle entry, so a same-cycle flush cannot stop it.
    assign w_ret_hit = ret_valid && r_ent[ret_tag].valid;
    assign w_ret_wb  = w_ret_hit && r_ent[ret_tag].wb && (r_ent[ret_tag].rd != 5'd0);

    always_comb begin
        rs1_stall = 1'b0;
        rs2_stall = 1'b0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (r_ent[i].valid && r_ent[i].wb) begin
                if (rs1_addr != 5'd0 && r_ent[i].rd == rs1_addr) rs1_stall = 1'b1;
                if (rs2_addr != 5'd0 && r_ent[i].rd == rs2_addr) rs2_stall = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                r_ent[i].valid <= 1'b0;
                r_ent[i].wb    <= 1'b0;
            end
            r_wb_valid     <= 1'b0;
            r_wb_rd        <= 5'd0;
            r_wb_tag       <= '0;
            r_ret_spurious <= 1'b0;
        end else begin
            assert (!alloc_gnt || ent_state(r_ent[alloc_tag]) == ENT_IDLE);
            for (int i = 0; i < NUM_TAGS; i++) begin
                if (flush || (alloc_gnt && r_ent[i].rd == alloc_rd)) r_ent[i].wb <= 1'b0;
                if (ret_valid && ret_tag == TAG_W'(i)) begin
                    r_ent[i].valid <= 1'b0;
                    r_ent[i].wb    <= 1'b0;
                end
                if (alloc_gnt && alloc_tag == TAG_W'(i)) begin
                    r_ent[i].valid <= 1'b1;
                    r_ent[i].wb    <= 1'b1;
                    r_ent[i].tag   <= alloc_tag;
                    r_ent[i].rd    <= alloc_rd;
                end
            end
            r_wb_valid     <= w_ret_wb;
            r_wb_rd        <= w_ret_wb ? r_ent[ret_tag].rd : 5'd0;
            r_wb_tag       <= w_ret_wb ? r_ent[ret_tag].tag : '0;
            r_ret_spurious <= ret_valid && !r_ent[ret_tag].valid;
        end
    end

    assign wb_valid     = r_wb_valid;
    assign wb_rd        = r_wb_rd;
    assign wb_tag       = r_wb_tag;
    assign ret_spurious = r_ret_spurious;

`ifdef RV_NBLOAD_PERF_EN
    logic [31:0] r_perf_full_cnt;
    logic [31:0] r_perf_alloc_cnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_full_cnt  <= 32'd0;
            r_perf_alloc_cnt <= 32'd0;
        end else begin
            if (alloc_req && full) r_perf_full_cnt  <= sat_inc(r_perf_full_cnt);
            if (alloc_gnt)         r_perf_alloc_cnt <= sat_inc(r_perf_alloc_cnt);
        end
    end

    assign perf_full_cnt  = r_perf_full_cnt;
    assign perf_alloc_cnt = r_perf_alloc_cnt;
`else
    assign perf_full_cnt  = 32'd0;
    assign perf_alloc_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_lsu_nbload_tag_ctl.sv
// Directed bench for lsu_nbload_tag_ctl: fill, return/writeback, WAW, flush,
// flush with return, rd==0, spurious return and mid-operation reset.
module tb_lsu_nbload_tag_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_req;
    logic [4:0]  alloc_rd;
    logic        alloc_gnt;
    logic [1:0]  alloc_tag;
    logic        full;
    logic        flush;
    logic        ret_valid;
    logic [1:0]  ret_tag;
    logic        ret_spurious;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_tag;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_stall;
    logic        rs2_stall;
    logic [31:0] perf_full_cnt;
    logic [31:0] perf_alloc_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    lsu_nbload_tag_ctl dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_req      (alloc_req),
        .alloc_rd       (alloc_rd),
        .alloc_gnt      (alloc_gnt),
        .alloc_tag      (alloc_tag),
        .full           (full),
        .flush          (flush),
        .ret_valid      (ret_valid),
        .ret_tag        (ret_tag),
        .ret_spurious   (ret_spurious),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_tag         (wb_tag),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .rs1_stall      (rs1_stall),
        .rs2_stall      (rs2_stall),
        .perf_full_cnt  (perf_full_cnt),
        .perf_alloc_cnt (perf_alloc_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Allocate with a check of the combinational grant, then clock it in.
    task automatic alloc(input logic [4:0] rd, input logic [1:0] exp_tag, input string tag);
        alloc_req = 1'b1;
        alloc_rd  = rd;
        #1;
        chk({tag, "_gnt"}, 32'(alloc_gnt), 32'd1);
        chk({tag, "_tag"}, 32'(alloc_tag), 32'(exp_tag));
        tick();
        alloc_req = 1'b0;
    endtask

    logic [4:0] drain_rd [4];
    logic [31:0] exp_full_perf;
    logic [31:0] exp_alloc_perf;

    initial begin
        rst = 1'b1; alloc_req = 1'b0; alloc_rd = 5'd0; flush = 1'b0;
        ret_valid = 1'b0; ret_tag = 2'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_gnt", 32'(alloc_gnt), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_spurious", 32'(ret_spurious), 32'd0);
        chk("rst_perf_full", perf_full_cnt, 32'd0);
        chk("rst_perf_alloc", perf_alloc_cnt, 32'd0);

        // Fill all four tags
        for (int k = 1; k <= 4; k++) alloc(5'(k), 2'(k - 1), "fill");
        alloc_req = 1'b1; alloc_rd = 5'd6;
        rs1_addr = 5'd3; rs2_addr = 5'd0;
        #1;
        chk("full_flag", 32'(full), 32'd1);
        chk("full_no_gnt", 32'(alloc_gnt), 32'd0);
        chk("pend_stall_rs1", 32'(rs1_stall), 32'd1);
        chk("rs2_zero_nostall", 32'(rs2_stall), 32'd0);
        tick();
`ifdef RV_NBLOAD_PERF_EN
        exp_full_perf = 32'd1; exp_alloc_perf = 32'd4;
`else
        exp_full_perf = 32'd0; exp_alloc_perf = 32'd0;
`endif
        chk("perf_full_1", perf_full_cnt, exp_full_perf);
        chk("perf_alloc_4", perf_alloc_cnt, exp_alloc_perf);

        // Return tag 2 with a same-cycle request that must be denied
        ret_valid = 1'b1; ret_tag = 2'd2; alloc_rd = 5'd7;
        #1;
        chk("ret_cycle_no_gnt", 32'(alloc_gnt), 32'd0);
        tick();
        ret_valid = 1'b0;
        chk("wb2_valid", 32'(wb_valid), 32'd1);
        chk("wb2_rd", 32'(wb_rd), 32'd3);
        chk("wb2_tag", 32'(wb_tag), 32'd2);
        alloc(5'd7, 2'd2, "realloc");
        chk("wb2_done", 32'(wb_valid), 32'd0);
`ifdef RV_NBLOAD_PERF_EN
        exp_full_perf = 32'd2; exp_alloc_perf = 32'd5;
`endif
        chk("perf_full_2", perf_full_cnt, exp_full_perf);
        chk("perf_alloc_5", perf_alloc_cnt, exp_alloc_perf);

        // Drain every tag
        drain_rd[0] = 5'd1; drain_rd[1] = 5'd2; drain_rd[2] = 5'd7; drain_rd[3] = 5'd4;
        for (int t = 0; t < 4; t++) begin
            ret_valid = 1'b1; ret_tag = 2'(t);
            tick();
            chk("drain_valid", 32'(wb_valid), 32'd1);
            chk("drain_rd", 32'(wb_rd), 32'(drain_rd[t]));
            chk("drain_tag", 32'(wb_tag), 32'(t));
        end
        ret_valid = 1'b0;

        // WAW: second rd=5 kills the first
        alloc(5'd5, 2'd0, "waw0");
        alloc(5'd5, 2'd1, "waw1");
        rs1_addr = 5'd5;
        #1;
        chk("waw_stall", 32'(rs1_stall), 32'd1);
        ret_valid = 1'b1; ret_tag = 2'd0;
        tick();
        chk("waw_killed_nowb", 32'(wb_valid), 32'd0);
        chk("waw_killed_nospur", 32'(ret_spurious), 32'd0);
        ret_tag = 2'd1;
        tick();
        ret_valid = 1'b0;
        chk("waw_wb_valid", 32'(wb_valid), 32'd1);
        chk("waw_wb_rd", 32'(wb_rd), 32'd5);
        chk("waw_wb_tag", 32'(wb_tag), 32'd1);
        #1;
        chk("waw_stall_gone", 32'(rs1_stall), 32'd0);

        // Flush kills pending entries and blocks the grant
        alloc(5'd8, 2'd0, "fl0");
        alloc(5'd9, 2'd1, "fl1");
        rs1_addr = 5'd8; rs2_addr = 5'd9;
        #1;
        chk("fl_stall1", 32'(rs1_stall), 32'd1);
        chk("fl_stall2", 32'(rs2_stall), 32'd1);
        flush = 1'b1; alloc_req = 1'b1; alloc_rd = 5'd10;
        #1;
        chk("fl_no_gnt", 32'(alloc_gnt), 32'd0);
        tick();
        flush = 1'b0; alloc_req = 1'b0;
        #1;
        chk("fl_stall1_drop", 32'(rs1_stall), 32'd0);
        chk("fl_stall2_drop", 32'(rs2_stall), 32'd0);
        for (int t = 0; t < 2; t++) begin
            ret_valid = 1'b1; ret_tag = 2'(t);
            tick();
            chk("fl_ret_nowb", 32'(wb_valid), 32'd0);
        end
        ret_valid = 1'b0;

        // Flush together with a return to a pending tag
        alloc(5'd11, 2'd0, "flr0");
        alloc(5'd12, 2'd1, "flr1");
        flush = 1'b1; ret_valid = 1'b1; ret_tag = 2'd0;
        tick();
        flush = 1'b0; ret_tag = 2'd1;
        chk("flr_wb_valid", 32'(wb_valid), 32'd1);
        chk("flr_wb_rd", 32'(wb_rd), 32'd11);
        chk("flr_wb_tag", 32'(wb_tag), 32'd0);
        tick();
        ret_valid = 1'b0;
        chk("flr_killed_nowb", 32'(wb_valid), 32'd0);

        // rd==0 never stalls or writes back
        alloc(5'd0, 2'd0, "rd0");
        rs1_addr = 5'd0;
        #1;
        chk("rd0_nostall", 32'(rs1_stall), 32'd0);
        ret_valid = 1'b1; ret_tag = 2'd0;
        tick();
        chk("rd0_nowb", 32'(wb_valid), 32'd0);

        // Spurious return to an idle tag
        ret_tag = 2'd3;
        tick();
        ret_valid = 1'b0;
        chk("spur_pulse", 32'(ret_spurious), 32'd1);
        chk("spur_nowb", 32'(wb_valid), 32'd0);
        tick();
        chk("spur_clear", 32'(ret_spurious), 32'd0);

        // Reset with entries pending
        alloc(5'd13, 2'd0, "mr0");
        alloc(5'd14, 2'd1, "mr1");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rs1_addr = 5'd13;
        #1;
        chk("mr_full", 32'(full), 32'd0);
        chk("mr_wb_valid", 32'(wb_valid), 32'd0);
        chk("mr_stall", 32'(rs1_stall), 32'd0);
        chk("mr_perf_full", perf_full_cnt, 32'd0);
        chk("mr_perf_alloc", perf_alloc_cnt, 32'd0);
        alloc(5'd15, 2'd0, "mr_first");
        ret_valid = 1'b1; ret_tag = 2'd1;
        tick();
        ret_valid = 1'b0;
        chk("mr_ret_spurious", 32'(ret_spurious), 32'd1);
        chk("mr_ret_nowb", 32'(wb_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
